// File: rtl/reservation_station_param.sv
// Parameterized reservation station: lowest-free-slot allocation, multi-channel CDB wakeup,
// oldest-first (ROB-age) selection into a registered dispatch stage.

// Operand wakeup for one tag against all CDB channels; the lowest channel wins.
module rs_wake #(
  parameter int NUM_CDB   = 2,
  parameter int ROB_IDX_W = 4,
  parameter int WORD_W    = 32
) (
  input  logic [ROB_IDX_W-1:0]              tag_i,
  input  logic [NUM_CDB-1:0]                cdb_en_i,
  input  logic [NUM_CDB-1:0][ROB_IDX_W-1:0] cdb_tag_i,
  input  logic [NUM_CDB-1:0][WORD_W-1:0]    cdb_res_i,
  output logic                              hit_o,
  output logic [WORD_W-1:0]                 res_o
);
  always_comb begin
    hit_o = 1'b0;
    res_o = '0;
    // Walk high to low so the lowest matching channel is the last one written.
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_en_i[k] && (tag_i != '0) && (cdb_tag_i[k] == tag_i)) begin
        hit_o = 1'b1;
        res_o = cdb_res_i[k];
      end
    end
  end
endmodule

module reservation_station_param #(
  parameter  int RS_DEPTH   = 16,
  parameter  int NUM_CDB    = 2,
  parameter  int ROB_IDX_W  = 4,
  parameter  int WORD_W     = 32,
  parameter  int INSTR_ID_W = 6,
  parameter  int IMM_W      = 32,
  parameter  int ADDR_W     = 32,
  localparam int CNT_W      = $clog2(RS_DEPTH + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic                          issue_valid_in,
  output logic                          issue_ready_out,
  input  logic [INSTR_ID_W-1:0]         instr_id_in,
  input  logic [IMM_W-1:0]              imm_in,
  input  logic [ADDR_W-1:0]             pc_in,
  input  logic [ROB_IDX_W-1:0]          rob_pos_in,
  input  logic [ROB_IDX_W-1:0]          rs1_tag_in,
  input  logic [ROB_IDX_W-1:0]          rs2_tag_in,
  input  logic [WORD_W-1:0]             rs1_val_in,
  input  logic [WORD_W-1:0]             rs2_val_in,
  input  logic [NUM_CDB-1:0]            cdb_en_in,
  input  logic [NUM_CDB*ROB_IDX_W-1:0]  cdb_tag_in,
  input  logic [NUM_CDB*WORD_W-1:0]     cdb_res_in,
  input  logic [ROB_IDX_W-1:0]          rob_head_in,
  output logic                          ex_valid_out,
  input  logic                          ex_ready_in,
  output logic [INSTR_ID_W-1:0]         ex_instr_id_out,
  output logic [IMM_W-1:0]              ex_imm_out,
  output logic [WORD_W-1:0]             ex_rs1_out,
  output logic [WORD_W-1:0]             ex_rs2_out,
  output logic [ADDR_W-1:0]             ex_pc_out,
  output logic [ROB_IDX_W-1:0]          ex_rob_pos_out,
  output logic [CNT_W-1:0]              count_out
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  typedef struct packed {
    logic                  busy;
    logic [ROB_IDX_W-1:0]  t1;
    logic [ROB_IDX_W-1:0]  t2;
    logic [WORD_W-1:0]     v1;
    logic [WORD_W-1:0]     v2;
    logic [INSTR_ID_W-1:0] id;
    logic [IMM_W-1:0]      imm;
    logic [ADDR_W-1:0]     pc;
    logic [ROB_IDX_W-1:0]  rob;
  } ent_t;

  typedef struct packed {
    logic [INSTR_ID_W-1:0] id;
    logic [IMM_W-1:0]      imm;
    logic [WORD_W-1:0]     rs1;
    logic [WORD_W-1:0]     rs2;
    logic [ADDR_W-1:0]     pc;
    logic [ROB_IDX_W-1:0]  rob;
  } ex_t;

  ent_t [RS_DEPTH-1:0] ent_q, ent_d;
  ex_t                 ex_q, ex_d;
  logic                ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [NUM_CDB-1:0][ROB_IDX_W-1:0] cdb_tag_a;
  logic [NUM_CDB-1:0][WORD_W-1:0]    cdb_res_a;
  assign cdb_tag_a = cdb_tag_in;
  assign cdb_res_a = cdb_res_in;

  logic [RS_DEPTH-1:0]                w1_hit, w2_hit, rdy_vec;
  logic [RS_DEPTH-1:0][WORD_W-1:0]    w1_res, w2_res;
  logic [RS_DEPTH-1:0][ROB_IDX_W-1:0] age;

  // Per-slot wakeup, readiness and age relative to the ROB head.
  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_slot
    rs_wake #(.NUM_CDB(NUM_CDB), .ROB_IDX_W(ROB_IDX_W), .WORD_W(WORD_W)) u_w1 (
      .tag_i(ent_q[i].t1), .cdb_en_i(cdb_en_in), .cdb_tag_i(cdb_tag_a),
      .cdb_res_i(cdb_res_a), .hit_o(w1_hit[i]), .res_o(w1_res[i]));
    rs_wake #(.NUM_CDB(NUM_CDB), .ROB_IDX_W(ROB_IDX_W), .WORD_W(WORD_W)) u_w2 (
      .tag_i(ent_q[i].t2), .cdb_en_i(cdb_en_in), .cdb_tag_i(cdb_tag_a),
      .cdb_res_i(cdb_res_a), .hit_o(w2_hit[i]), .res_o(w2_res[i]));
    assign rdy_vec[i] = ent_q[i].busy && (ent_q[i].t1 == '0) && (ent_q[i].t2 == '0);
    assign age[i]     = ent_q[i].rob - rob_head_in;
  end

  // Issue-time bypass: an operand whose producer broadcasts this cycle never waits.
  logic              i1_hit, i2_hit;
  logic [WORD_W-1:0] i1_res, i2_res;
  rs_wake #(.NUM_CDB(NUM_CDB), .ROB_IDX_W(ROB_IDX_W), .WORD_W(WORD_W)) u_iw1 (
    .tag_i(rs1_tag_in), .cdb_en_i(cdb_en_in), .cdb_tag_i(cdb_tag_a),
    .cdb_res_i(cdb_res_a), .hit_o(i1_hit), .res_o(i1_res));
  rs_wake #(.NUM_CDB(NUM_CDB), .ROB_IDX_W(ROB_IDX_W), .WORD_W(WORD_W)) u_iw2 (
    .tag_i(rs2_tag_in), .cdb_en_i(cdb_en_in), .cdb_tag_i(cdb_tag_a),
    .cdb_res_i(cdb_res_a), .hit_o(i2_hit), .res_o(i2_res));

  logic                 sel_vld;
  logic [IDX_W-1:0]     sel_idx, alloc_idx;
  logic [ROB_IDX_W-1:0] sel_age;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_age = '0;
    // Strict less-than keeps the lowest slot on equal age.
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (rdy_vec[i] && (!sel_vld || (age[i] < sel_age))) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
        sel_age = age[i];
      end
    end
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) alloc_idx = IDX_W'(i);
    end
  end

  logic issue_fire, disp_load, disp_fire;
  assign issue_ready_out = (count_q < CNT_W'(RS_DEPTH));
  assign issue_fire      = issue_valid_in && issue_ready_out && rdy_in && !flush_in;
  assign disp_load       = !ex_valid_q || ex_ready_in;
  assign disp_fire       = rdy_in && !flush_in && disp_load && sel_vld;

  always_comb begin
    ent_d      = ent_q;
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    count_d    = count_q;
    if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < RS_DEPTH; i++) ent_d[i].busy = 1'b0;
        ex_valid_d = 1'b0;
        count_d    = '0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (ent_q[i].busy && w1_hit[i]) begin
            ent_d[i].t1 = '0;
            ent_d[i].v1 = w1_res[i];
          end
          if (ent_q[i].busy && w2_hit[i]) begin
            ent_d[i].t2 = '0;
            ent_d[i].v2 = w2_res[i];
          end
        end
        if (disp_load) begin
          ex_valid_d = sel_vld;
          if (sel_vld) begin
            ex_d.id  = ent_q[sel_idx].id;
            ex_d.imm = ent_q[sel_idx].imm;
            ex_d.rs1 = ent_q[sel_idx].v1;
            ex_d.rs2 = ent_q[sel_idx].v2;
            ex_d.pc  = ent_q[sel_idx].pc;
            ex_d.rob = ent_q[sel_idx].rob;
            ent_d[sel_idx].busy = 1'b0;
          end
        end
        if (issue_fire) begin
          ent_d[alloc_idx].busy = 1'b1;
          ent_d[alloc_idx].t1   = i1_hit ? '0 : rs1_tag_in;
          ent_d[alloc_idx].t2   = i2_hit ? '0 : rs2_tag_in;
          ent_d[alloc_idx].v1   = (rs1_tag_in == '0) ? rs1_val_in : i1_res;
          ent_d[alloc_idx].v2   = (rs2_tag_in == '0) ? rs2_val_in : i2_res;
          ent_d[alloc_idx].id   = instr_id_in;
          ent_d[alloc_idx].imm  = imm_in;
          ent_d[alloc_idx].pc   = pc_in;
          ent_d[alloc_idx].rob  = rob_pos_in;
        end
        count_d = count_q + CNT_W'(issue_fire) - CNT_W'(disp_fire);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ent_q      <= '0;
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      ent_q      <= ent_d;
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      count_q    <= count_d;
    end
  end

  assign ex_valid_out    = ex_valid_q;
  assign ex_instr_id_out = ex_q.id;
  assign ex_imm_out      = ex_q.imm;
  assign ex_rs1_out      = ex_q.rs1;
  assign ex_rs2_out      = ex_q.rs2;
  assign ex_pc_out       = ex_q.pc;
  assign ex_rob_pos_out  = ex_q.rob;
  assign count_out       = count_q;
endmodule

// File: tb/tb_reservation_station_param.sv
// Bench: slot-level behavioural model checked every cycle, plus hand-computed directed expectations.
module tb_reservation_station_param;
  localparam int DEPTH = 8;
  localparam int NCDB  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rdy_in, flush_in, issue_valid_in, issue_ready_out, ex_valid_out, ex_ready_in;
  logic [5:0]  instr_id_in, ex_instr_id_out;
  logic [31:0] imm_in, pc_in, rs1_val_in, rs2_val_in, ex_imm_out, ex_rs1_out, ex_rs2_out, ex_pc_out;
  logic [3:0]  rob_pos_in, rs1_tag_in, rs2_tag_in, rob_head_in, ex_rob_pos_out, count_out;
  logic [NCDB-1:0]            cdb_en_in;
  logic [NCDB-1:0][3:0]       cdb_tag_a;
  logic [NCDB-1:0][31:0]      cdb_res_a;

  reservation_station_param #(.RS_DEPTH(DEPTH), .NUM_CDB(NCDB)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
    .instr_id_in(instr_id_in), .imm_in(imm_in), .pc_in(pc_in), .rob_pos_in(rob_pos_in),
    .rs1_tag_in(rs1_tag_in), .rs2_tag_in(rs2_tag_in), .rs1_val_in(rs1_val_in), .rs2_val_in(rs2_val_in),
    .cdb_en_in(cdb_en_in), .cdb_tag_in(cdb_tag_a), .cdb_res_in(cdb_res_a), .rob_head_in(rob_head_in),
    .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in), .ex_instr_id_out(ex_instr_id_out),
    .ex_imm_out(ex_imm_out), .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out), .ex_pc_out(ex_pc_out),
    .ex_rob_pos_out(ex_rob_pos_out), .count_out(count_out));

  // Behavioural model: slots with payload, plus the dispatched output register.
  logic        m_busy[DEPTH];
  logic [3:0]  m_t1[DEPTH], m_t2[DEPTH], m_rob[DEPTH];
  logic [31:0] m_v1[DEPTH], m_v2[DEPTH], m_imm[DEPTH], m_pc[DEPTH];
  logic [5:0]  m_id[DEPTH];
  logic        m_exv;
  logic [5:0]  m_ex_id;
  logic [31:0] m_ex_imm, m_ex_rs1, m_ex_rs2, m_ex_pc;
  logic [3:0]  m_ex_rob;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic void cdb_lookup(input logic [3:0] t, output logic hit, output logic [31:0] r);
    hit = 1'b0;
    r   = '0;
    if (t != 4'd0)
      for (int k = 0; k < NCDB; k++)
        if (!hit && cdb_en_in[k] && cdb_tag_a[k] == t) begin
          hit = 1'b1;
          r   = cdb_res_a[k];
        end
  endfunction

  initial forever begin
    int best, slot;
    logic [3:0] bage, a;
    logic h;
    logic [31:0] r;
    logic fire;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      m_exv = 0; m_ex_id = 0; m_ex_imm = 0; m_ex_rs1 = 0; m_ex_rs2 = 0; m_ex_pc = 0; m_ex_rob = 0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        m_exv = 1'b0;
      end else begin
        best = -1; bage = 0;
        for (int i = 0; i < DEPTH; i++) begin
          a = m_rob[i] - rob_head_in;
          if (m_busy[i] && m_t1[i] == 0 && m_t2[i] == 0 && (best < 0 || a < bage)) begin
            best = i; bage = a;
          end
        end
        slot = -1;
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i] && slot < 0) slot = i;
        fire = issue_valid_in && (m_count() < DEPTH);
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) begin
          cdb_lookup(m_t1[i], h, r); if (h) begin m_t1[i] = 0; m_v1[i] = r; end
          cdb_lookup(m_t2[i], h, r); if (h) begin m_t2[i] = 0; m_v2[i] = r; end
        end
        if (!m_exv || ex_ready_in) begin
          m_exv = (best >= 0);
          if (best >= 0) begin
            m_ex_id = m_id[best]; m_ex_imm = m_imm[best]; m_ex_rs1 = m_v1[best];
            m_ex_rs2 = m_v2[best]; m_ex_pc = m_pc[best]; m_ex_rob = m_rob[best];
            m_busy[best] = 1'b0;
          end
        end
        if (fire) begin
          m_busy[slot] = 1'b1; m_rob[slot] = rob_pos_in; m_id[slot] = instr_id_in;
          m_imm[slot] = imm_in; m_pc[slot] = pc_in;
          if (rs1_tag_in == 0) begin m_t1[slot] = 0; m_v1[slot] = rs1_val_in; end
          else begin
            cdb_lookup(rs1_tag_in, h, r);
            m_t1[slot] = h ? 4'd0 : rs1_tag_in; m_v1[slot] = r;
          end
          if (rs2_tag_in == 0) begin m_t2[slot] = 0; m_v2[slot] = rs2_val_in; end
          else begin
            cdb_lookup(rs2_tag_in, h, r);
            m_t2[slot] = h ? 4'd0 : rs2_tag_in; m_v2[slot] = r;
          end
        end
      end
    end
  end

  // Directed expectations queued by the stimulus, evaluated at the next falling edge.
  string       lit_name[256];
  int          lit_sel[256];
  logic [31:0] lit_exp[256];
  int          lit_wr = 0;
  logic        chk_on = 1'b0, done = 1'b0;
  int          n_tests = 0, n_fail = 0;

  function automatic logic [31:0] sig_of(input int s);
    case (s)
      0: return 32'(ex_valid_out);
      1: return 32'(count_out);
      2: return 32'(issue_ready_out);
      3: return ex_rs1_out;
      4: return ex_rs2_out;
      5: return 32'(ex_rob_pos_out);
      6: return ex_imm_out;
      default: return 32'(ex_instr_id_out);
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  initial begin
    int lit_rd = 0;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("ex_valid", 32'(ex_valid_out), 32'(m_exv));
        chk("count", 32'(count_out), 32'(m_count()));
        chk("issue_ready", 32'(issue_ready_out), 32'(m_count() < DEPTH));
        if (m_exv) begin
          chk("ex_id", 32'(ex_instr_id_out), 32'(m_ex_id));
          chk("ex_imm", ex_imm_out, m_ex_imm);
          chk("ex_rs1", ex_rs1_out, m_ex_rs1);
          chk("ex_rs2", ex_rs2_out, m_ex_rs2);
          chk("ex_pc", ex_pc_out, m_ex_pc);
          chk("ex_rob", 32'(ex_rob_pos_out), 32'(m_ex_rob));
        end
      end
      while (lit_rd < lit_wr) begin
        chk(lit_name[lit_rd], sig_of(lit_sel[lit_rd]), lit_exp[lit_rd]);
        lit_rd++;
      end
      if (done) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  task automatic lit(input string n, input int s, input logic [31:0] v);
    lit_name[lit_wr] = n; lit_sel[lit_wr] = s; lit_exp[lit_wr] = v; lit_wr++;
  endtask

  task automatic cyc();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic idle();
    issue_valid_in = 0; cdb_en_in = 0; flush_in = 0;
  endtask

  task automatic iss(input logic [3:0] rob, input logic [3:0] t1, input logic [3:0] t2,
                     input logic [31:0] v1, input logic [31:0] v2);
    issue_valid_in = 1; rob_pos_in = rob; rs1_tag_in = t1; rs2_tag_in = t2;
    rs1_val_in = v1; rs2_val_in = v2;
    instr_id_in = 6'($urandom); imm_in = $urandom; pc_in = $urandom;
  endtask

  task automatic cdb(input int k, input logic [3:0] t, input logic [31:0] r);
    cdb_en_in[k] = 1'b1; cdb_tag_a[k] = t; cdb_res_a[k] = r;
  endtask

  initial begin
    rst_n = 0; rdy_in = 1; flush_in = 0; issue_valid_in = 0; ex_ready_in = 1;
    instr_id_in = 0; imm_in = 0; pc_in = 0; rob_pos_in = 0; rs1_tag_in = 0; rs2_tag_in = 0;
    rs1_val_in = 0; rs2_val_in = 0; cdb_en_in = 0; cdb_tag_a = '0; cdb_res_a = '0; rob_head_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    lit("rst_exv", 0, 0); lit("rst_cnt", 1, 0); lit("rst_rdy", 2, 1);
    lit("rst_rs1", 3, 0); lit("rst_rob", 5, 0);
    rst_n = 1; chk_on = 1;
    cyc();

    // Tag-0 operands: dispatch one edge after the issue edge.
    iss(4'd3, 0, 0, 32'd5, 32'd7); lit("r37_cnt1", 1, 1); lit("r37_exv0", 0, 0);
    cyc();
    idle(); lit("r37_exv", 0, 1); lit("r37_rs1", 3, 5); lit("r37_rs2", 4, 7);
    lit("r37_rob", 5, 3); lit("r37_cnt0", 1, 0);
    cyc();
    lit("r37_drain", 0, 0);
    cyc();

    // Pending operand woken by CDB channel 1, then same-cycle bypass on channel 0.
    iss(4'd4, 4'd2, 0, 32'd0, 32'd9); lit("r38_cnt", 1, 1);
    cyc();
    idle(); lit("r38_wait", 0, 0);
    cyc();
    cdb(1, 4'd2, 32'hAA); lit("r38_cap", 0, 0);
    cyc();
    idle(); lit("r38_exv", 0, 1); lit("r38_rs1", 3, 32'hAA); lit("r38_rs2", 4, 9); lit("r38_rob", 5, 4);
    cyc();
    iss(4'd5, 4'd2, 0, 32'd0, 32'd1); cdb(0, 4'd2, 32'h55); cdb(1, 4'd2, 32'h66);
    lit("r38b_cnt", 1, 1);
    cyc();
    idle(); lit("r38b_exv", 0, 1); lit("r38b_rs1", 3, 32'h55); lit("r38b_rob", 5, 5);
    cyc();
    cyc();

    // Age order relative to the ROB head: rob 9 (age 1) beats rob 1 (age 9).
    rob_head_in = 4'd8;
    iss(4'd1, 4'd6, 0, 0, 32'h11);
    cyc();
    iss(4'd9, 4'd6, 0, 0, 32'h99);
    cyc();
    idle(); cdb(0, 4'd6, 32'h77); lit("r39_cap", 0, 0);
    cyc();
    idle(); lit("r39_first", 5, 9); lit("r39_rs1", 3, 32'h77);
    cyc();
    lit("r39_second", 5, 1);
    cyc();
    lit("r39_done", 0, 0);
    cyc();
    rob_head_in = 4'd0;

    // Fill with the output stalled, then hold, release one, drain to three, flush.
    ex_ready_in = 0;
    for (int i = 0; i < 12; i++) begin
      iss(4'(i + 1), 0, 0, 32'h100 + i, 32'h200 + i);
      if (i == 11) begin
        lit("r40_cnt", 1, DEPTH); lit("r40_rdy", 2, 0); lit("r40_exv", 0, 1); lit("r40_rob", 5, 1);
      end
      cyc();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      lit("r41_exv", 0, 1); lit("r41_rob", 5, 1); lit("r41_rs1", 3, 32'h100); lit("r41_cnt", 1, DEPTH);
      cyc();
    end
    ex_ready_in = 1; lit("r40_rel_cnt", 1, DEPTH - 1); lit("r40_rel_rdy", 2, 1); lit("r40_rel_rob", 5, 2);
    cyc();
    repeat (4) cyc();
    ex_ready_in = 0; lit("r42_pre_cnt", 1, 3); lit("r42_pre_rob", 5, 6);
    cyc();
    iss(4'd12, 0, 0, 1, 2); flush_in = 1; ex_ready_in = 1;
    lit("r42_cnt", 1, 0); lit("r42_exv", 0, 0); lit("r42_rdy", 2, 1);
    cyc();
    idle(); lit("r42_after", 0, 0);
    cyc();

    // Randomized traffic including stalls, freezes and flushes.
    for (int c = 0; c < 2000; c++) begin
      issue_valid_in = ($urandom_range(0, 9) < 6);
      rob_pos_in  = 4'($urandom);
      rs1_tag_in  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      rs2_tag_in  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      rs1_val_in  = $urandom; rs2_val_in = $urandom;
      instr_id_in = 6'($urandom); imm_in = $urandom; pc_in = $urandom;
      cdb_en_in   = 2'($urandom);
      for (int k = 0; k < NCDB; k++) begin
        cdb_tag_a[k] = 4'($urandom_range(1, 15));
        cdb_res_a[k] = $urandom;
      end
      ex_ready_in = ($urandom_range(0, 9) < 7);
      flush_in    = ($urandom_range(0, 49) == 0);
      rdy_in      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) rob_head_in = 4'($urandom);
      cyc();
    end
    idle(); rdy_in = 1;

    // Asynchronous reset while a dispatch is held on the output.
    ex_ready_in = 0; rob_head_in = 0;
    iss(4'd2, 0, 0, 32'h5, 32'h6);
    cyc();
    iss(4'd3, 0, 0, 32'h7, 32'h8);
    cyc();
    idle();
    rst_n = 0;
    lit("r36_exv", 0, 0); lit("r36_cnt", 1, 0); lit("r36_rdy", 2, 1); lit("r36_rs1", 3, 0); lit("r36_rob", 5, 0);
    cyc();
    rst_n = 1; ex_ready_in = 1;
    cyc();
    iss(4'd7, 0, 0, 32'h123, 32'h456); lit("r36_resume_cnt", 1, 1);
    cyc();
    idle(); lit("r36_resume_exv", 0, 1); lit("r36_resume_rs1", 3, 32'h123);
    cyc();
    done = 1;
    #1000;
    $display("FAIL watchdog: summary not reached");
    $fatal(1);
  end
endmodule
